// File: rtl/multi_div.sv
// multi_div: N_CH independent clock dividers with tick/square outputs and shadowed, wrap-synchronous reconfiguration
module multi_div #(
  parameter int N_CH = 4,
  parameter int W = 16,
  parameter int DEF_DIV = 7,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic [N_CH-1:0] en,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [W-1:0]    cfg_div,
  input  logic            cfg_mode,
  input  logic            sync_all,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] cfg_pending
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [W-1:0] r_cnt, r_div, r_sdiv;
    logic r_mode, r_smode, r_pend, r_tick, r_clk;
    logic w_we, w_run, w_wrap, w_apply;
    logic [W-1:0] w_ndiv;
    logic w_nmode;
    assign w_we = cfg_we && cfg_ch == CW'(g);
    assign w_run = en[g] && r_div != '0;
    assign w_wrap = w_run && r_cnt == r_div - W'(1);
    // idle channels and sync_all adopt pending config immediately; a same-edge write takes priority
    assign w_apply = w_wrap || !w_run || sync_all;
    assign w_ndiv = w_we ? cfg_div : r_sdiv;
    assign w_nmode = w_we ? cfg_mode : r_smode;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_cnt <= '0;
        r_div <= W'(DEF_DIV);
        r_sdiv <= W'(DEF_DIV);
        r_mode <= 1'b0;
        r_smode <= 1'b0;
        r_pend <= 1'b0;
        r_tick <= 1'b0;
        r_clk <= 1'b0;
      end else begin
        r_tick <= w_wrap && !sync_all;
        r_clk <= w_run && !sync_all && (r_mode ? r_cnt < (r_div >> 1) : w_wrap);
        r_cnt <= (w_run && !w_wrap && !sync_all) ? r_cnt + W'(1) : '0;
        if (w_apply) begin
          r_div <= w_ndiv;
          r_mode <= w_nmode;
          r_sdiv <= w_ndiv;
          r_smode <= w_nmode;
          r_pend <= 1'b0;
        end else if (w_we) begin
          r_sdiv <= cfg_div;
          r_smode <= cfg_mode;
          r_pend <= 1'b1;
        end
      end
    end
    assign tick[g] = r_tick;
    assign clk_out[g] = r_clk;
    assign cfg_pending[g] = r_pend;
  end
endmodule

// File: doc/multi_div.md
MULTI_DIV -- requirements
Module: multi_div

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter W, default 16: divisor and counter width in bits.
REQ-003 Parameter DEF_DIV, default 7: reset-time divisor of every channel (1..2^W-1).
REQ-004 CW = max(1, $clog2(N_CH)); channel index width.
REQ-005 sys_clk  in  1  the single clock; all state is on its rising edge.
REQ-006 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  N_CH  per-channel run enable.
REQ-008 cfg_we  in  1  config write strobe, one-cycle, sampled on the rising edge.
REQ-009 cfg_ch  in  CW  target channel of the write.
REQ-010 cfg_div  in  W  new divisor D.
REQ-011 cfg_mode  in  1  new mode: 0 = pulse, 1 = square.
REQ-012 sync_all  in  1  phase-align strobe for all channels.
REQ-013 tick  out  N_CH  one-cycle pulse per channel period.
REQ-014 clk_out  out  N_CH  registered square-wave output per channel.
REQ-015 cfg_pending  out  N_CH  shadow config written but not yet active.

Function
REQ-016 Each channel SHALL hold an active divisor D_act, an active mode M_act, a shadow divisor/mode pair, and a W-bit counter cnt.
REQ-017 Running (en=1, D_act>=1): cnt counts 0..D_act-1 and wraps to 0; a wrap is the cycle where cnt==D_act-1.
REQ-018 tick[i] SHALL be 1 exactly in wrap cycles of a running channel, in both modes.
REQ-019 clk_out[i] in square mode SHALL be 1 exactly in cycles where cnt < (D_act>>1), driven from a flop (no combinational path to the output).
- Odd D: high floor(D/2) cycles, low ceil(D/2) cycles.
- D=1: clk_out stays 0.
REQ-020 clk_out[i] in pulse mode SHALL equal tick[i], registered (same cycle as tick).
REQ-021 A write with cfg_ch < N_CH SHALL load the shadow and set cfg_pending[cfg_ch] on the next edge; a write with cfg_ch >= N_CH SHALL be ignored.
REQ-022 Pending shadow SHALL be copied into D_act/M_act at the channel's next wrap edge, clearing cfg_pending; the counter restarts at 0 with the new values.
REQ-023 Write in the same cycle as a wrap of that channel: the written value SHALL be applied at that wrap edge directly, with cfg_pending staying 0.
REQ-024 A second write before application SHALL overwrite the shadow (last write wins).
REQ-025 Disabled channel (en=0) or D_act=0: cnt held 0, tick 0, clk_out 0; any pending shadow SHALL apply on the next edge.
REQ-026 On en 0->1, the first wrap SHALL occur D_act cycles after the first enabled edge (cnt starts from 0).
REQ-027 sync_all=1: on that edge all counters SHALL clear to 0 and all pending shadows (including a same-cycle write) SHALL be applied; no tick is generated in that cycle's wrap.
REQ-028 Channels SHALL be fully independent except through sync_all and the shared config bus.

Reset
REQ-029 While sys_rst_n=0, asynchronously: cnt=0, D_act=shadow=DEF_DIV, M_act=shadow mode=pulse, cfg_pending=0, clk_out=0, tick=0.
REQ-030 Reset asserted mid-period SHALL discard any pending configuration; operation resumes from REQ-029 state on the first edge after release.

Verification
REQ-031 Reset release, en=all 1, defaults -> tick on each channel every 7 cycles, first tick on the 7th enabled edge; clk_out equals tick.
REQ-032 Write ch1 D=4 mode=square mid-period -> cfg_pending[1]=1 until the next ch1 wrap; then clk_out[1] pattern is 1,1,0,0 repeating and tick[1] every 4 cycles; other channels unchanged.
REQ-033 ch2 D=5 square -> clk_out[2] high 2, low 3 cycles; D=1 square -> tick every cycle, clk_out stays 0.
REQ-034 Write ch0 on its wrap cycle, followed by two writes to ch3 (D=9, then D=3) before its wrap -> ch0 applies immediately, pending stays 0; ch3 adopts D=3 only.
REQ-035 sync_all pulsed with channels at differing phases plus a pending write -> all cnt=0 next cycle, pending cleared, subsequent ticks aligned to their divisors.
REQ-036 Assert sys_rst_n=0 mid-period with pending config, and drive en=0 or cfg_ch=N_CH -> REQ-029 values immediately; disabled channel outputs stay 0; out-of-range write has no effect.
